// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU with a valid/ready request side and a
// valid/ready result side. Non-shift ops (and zero-length shifts) finish in
// one cycle; SLL/SRL/SRA shift one bit per cycle, so a shift of N takes N+1
// cycles from acceptance to out_valid.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready only while IDLE)
//   alu_control        4-bit operation code from the ALU decoder
//   op_a, op_b         operands; op_b[4:0] is the shift amount
//   out_valid/out_ready result handshake
//   result, zero       result word and result==0 flag (0 when !out_valid)
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      work_q, work_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]      result_d;
  logic                 zero_d, valid_d, ready_d;
  logic [XLEN-1:0]      alu_c;
  logic [XLEN-1:0]      step_c;
  logic                 is_shift_c;

  // Single-cycle result; shift codes pass op_a through (the shamt==0 case).
  always_comb begin
    case (alu_control)
      OP_SUB:  alu_c = op_a - op_b;
      OP_AND:  alu_c = op_a & op_b;
      OP_OR:   alu_c = op_a | op_b;
      OP_XOR:  alu_c = op_a ^ op_b;
      OP_SLT:  alu_c = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_c = XLEN'(op_a < op_b);
      OP_SLL, OP_SRL, OP_SRA: alu_c = op_a;
      default: alu_c = op_a + op_b;
    endcase
  end

  assign is_shift_c = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

  // One-bit step of the captured shift op on the working register.
  always_comb begin
    case (ctrl_q)
      OP_SLL:  step_c = {work_q[XLEN-2:0], 1'b0};
      OP_SRA:  step_c = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step_c = {1'b0, work_q[XLEN-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    result_d = result;
    zero_d   = zero;
    valid_d  = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d = op_a;
          ctrl_d = alu_control;
          cnt_d  = op_b[SHAMT_W-1:0];
          if (is_shift_c && (op_b[SHAMT_W-1:0] != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d  = DONE;
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            valid_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = step_c;
        cnt_d  = cnt_q - SHAMT_W'(1);
        // Last step: publish the shifted word on the same edge.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = step_c;
          zero_d   = (step_c == '0);
          valid_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          zero_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      work_q    <= work_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      result    <= result_d;
      zero      <= zero_d;
      out_valid <= valid_d;
      in_ready  <= ready_d;
    end
  end

endmodule
